// File: rtl/emmc_loopback_seq.sv
// Write-then-read-back exerciser for emmc_sm: writes an incrementing pattern, reads it back, counts mismatches.
// Latency: start pulse one cycle after go_i; flow paced by emmc_ready_i / emmc_dvalid_i, aborts after TIMEOUT_CYC idle cycles.
module emmc_loopback_seq #(
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 256,
    parameter int GAP_CYC       = 16,
    parameter int TIMEOUT_CYC   = 1048576
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic [15:0]       blk_cnt_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              emmc_start_o,
    output logic              emmc_we_o,
    output logic [15:0]       emmc_blk_cnt_o,
    output logic [DATA_W-1:0] emmc_dat_o,
    input  logic              emmc_ready_i,
    input  logic [DATA_W-1:0] emmc_dat_i,
    input  logic              emmc_dvalid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [15:0]       err_cnt_o,
    output logic [31:0]       first_err_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_START, S_WR_DATA, S_GAP, S_RD_START, S_RD_DATA, S_DONE
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_seed;
    logic [31:0]       r_total;
    logic [31:0]       r_idx;
    logic [31:0]       r_timer;

    logic [31:0]       w_idx_nxt;
    logic              w_last;
    logic [DATA_W-1:0] w_exp;
    logic              w_mis;
    logic              w_to;
    logic              w_gap_end;
    logic [15:0]       w_err_nxt;

    assign w_idx_nxt = r_idx + 32'd1;
    assign w_last    = (w_idx_nxt == r_total);
    assign w_exp     = r_seed + DATA_W'(r_idx);
    assign w_mis     = (emmc_dat_i != w_exp);
    assign w_to      = ((r_timer + 32'd1) == 32'(TIMEOUT_CYC));
    assign w_gap_end = ((r_timer + 32'd1) >= 32'(GAP_CYC));
    assign w_err_nxt = (err_cnt_o == 16'hFFFF) ? err_cnt_o : err_cnt_o + 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_seed          <= '0;
            r_total         <= '0;
            r_idx           <= '0;
            r_timer         <= '0;
            emmc_start_o    <= 1'b0;
            emmc_we_o       <= 1'b0;
            emmc_blk_cnt_o  <= '0;
            emmc_dat_o      <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            timeout_o       <= 1'b0;
            err_cnt_o       <= '0;
            first_err_idx_o <= 32'hFFFF_FFFF;
        end else begin
            emmc_start_o <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (go_i) begin
                        r_seed          <= seed_i;
                        emmc_blk_cnt_o  <= blk_cnt_i;
                        r_total         <= 32'(blk_cnt_i) * 32'(WORDS_PER_BLK);
                        r_idx           <= '0;
                        r_timer         <= '0;
                        err_cnt_o       <= '0;
                        first_err_idx_o <= 32'hFFFF_FFFF;
                        timeout_o       <= 1'b0;
                        emmc_dat_o      <= seed_i;
                        if (blk_cnt_i == 16'd0) begin
                            // Empty run completes immediately without touching the card.
                            r_state   <= S_DONE;
                            done_o    <= 1'b1;
                            pass_o    <= 1'b1;
                            busy_o    <= 1'b0;
                            emmc_we_o <= 1'b0;
                        end else begin
                            r_state      <= S_WR_START;
                            emmc_start_o <= 1'b1;
                            emmc_we_o    <= 1'b1;
                            busy_o       <= 1'b1;
                            done_o       <= 1'b0;
                            pass_o       <= 1'b0;
                        end
                    end
                end
                S_WR_START: begin
                    r_state <= S_WR_DATA;
                    r_timer <= '0;
                end
                S_WR_DATA: begin
                    if (emmc_ready_i) begin
                        r_idx      <= w_idx_nxt;
                        emmc_dat_o <= r_seed + DATA_W'(w_idx_nxt);
                        r_timer    <= '0;
                        if (w_last) r_state <= S_GAP;
                    end else if (w_to) begin
                        r_state   <= S_DONE;
                        timeout_o <= 1'b1;
                        pass_o    <= 1'b0;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_GAP: begin
                    // The timer doubles as the gap counter; it is cleared again on read entry.
                    if (w_gap_end) begin
                        r_state      <= S_RD_START;
                        emmc_start_o <= 1'b1;
                        emmc_we_o    <= 1'b0;
                        r_idx        <= '0;
                        r_timer      <= '0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_RD_START: begin
                    r_state <= S_RD_DATA;
                    r_timer <= '0;
                end
                S_RD_DATA: begin
                    if (emmc_dvalid_i) begin
                        if (w_mis) begin
                            err_cnt_o <= w_err_nxt;
                            if (err_cnt_o == 16'd0) first_err_idx_o <= r_idx;
                        end
                        r_idx   <= w_idx_nxt;
                        r_timer <= '0;
                        if (w_last) begin
                            r_state <= S_DONE;
                            done_o  <= 1'b1;
                            busy_o  <= 1'b0;
                            pass_o  <= !w_mis && (err_cnt_o == 16'd0);
                        end
                    end else if (w_to) begin
                        r_state   <= S_DONE;
                        timeout_o <= 1'b1;
                        pass_o    <= 1'b0;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_emmc_loopback_seq.sv
// Bench for emmc_loopback_seq: an emmc_sm echo model plus a queue of expected write words and end-of-run results.
module tb_emmc_loopback_seq;
    localparam int DW  = 16;
    localparam int WPB = 256;
    localparam int GAP = 16;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          rst_i, go_i, emmc_ready_i, emmc_dvalid_i;
    logic [15:0]   blk_cnt_i;
    logic [DW-1:0] seed_i, emmc_dat_i;
    logic          emmc_start_o, emmc_we_o, busy_o, done_o, pass_o, timeout_o;
    logic [15:0]   emmc_blk_cnt_o, err_cnt_o;
    logic [DW-1:0] emmc_dat_o;
    logic [31:0]   first_err_idx_o;

    always #5 clk = ~clk;

    emmc_loopback_seq #(.DATA_W(DW), .WORDS_PER_BLK(WPB), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .go_i(go_i), .blk_cnt_i(blk_cnt_i), .seed_i(seed_i),
        .emmc_start_o(emmc_start_o), .emmc_we_o(emmc_we_o), .emmc_blk_cnt_o(emmc_blk_cnt_o),
        .emmc_dat_o(emmc_dat_o), .emmc_ready_i(emmc_ready_i), .emmc_dat_i(emmc_dat_i),
        .emmc_dvalid_i(emmc_dvalid_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] mem[$];
    int  cyc = 0;
    int  wr_left, rd_left, rd_idx, rd_limit, go_busy_at, cmode, cur_blk;
    int  start_cnt, wr_start_cyc, rd_start_cyc, last_beat, go_cyc;
    bit  wr_act, rd_act, toggle, tog;
    logic [DW-1:0] cur_seed;

    function automatic bit corrupt(input int k);
        return (cmode == 1) && (k == 10 || k == 20 || k == 30);
    endfunction

    // One cycle: sample DUT at the falling edge, then drive the emmc_sm model's inputs for the next rising edge.
    task automatic step();
        bit saw_start;
        @(negedge clk);
        cyc++;
        go_i = 1'b0; emmc_ready_i = 1'b0; emmc_dvalid_i = 1'b0;
        saw_start = emmc_start_o;
        if (saw_start) begin
            start_cnt++;
            chk("blk_cnt_o", 32'(emmc_blk_cnt_o), 32'(cur_blk));
        end
        if (wr_act && wr_left > 0) begin
            tog = ~tog;
            if (!toggle || tog) begin
                emmc_ready_i = 1'b1;
                if (wr_q.size() > 0) chk("wr_dat", 32'(emmc_dat_o), 32'(wr_q.pop_front()));
                mem.push_back(emmc_dat_o);
                wr_left--;
                if (wr_left == go_busy_at) begin
                    go_i = 1'b1; seed_i = ~cur_seed; blk_cnt_i = 16'd7;
                end
            end
        end
        if (rd_act && rd_left > 0 && rd_idx < rd_limit) begin
            emmc_dvalid_i = 1'b1;
            emmc_dat_i = mem[rd_idx] ^ (corrupt(rd_idx) ? 16'h0100 : 16'h0000);
            rd_idx++; rd_left--;
            last_beat = cyc;
        end
        if (saw_start && emmc_we_o)  begin wr_act = 1'b1; wr_start_cyc = cyc; end
        if (saw_start && !emmc_we_o) begin rd_act = 1'b1; rd_start_cyc = cyc; end
    endtask

    task automatic begin_run(input int blk, input logic [DW-1:0] seed, input bit tmode,
                             input int cm, input int limit, input int busy_at);
        wr_q.delete(); mem.delete();
        wr_act = 0; rd_act = 0; rd_idx = 0; tog = 0; start_cnt = 0;
        wr_left = blk * WPB; rd_left = blk * WPB; toggle = tmode; cmode = cm;
        rd_limit = limit; go_busy_at = busy_at; cur_blk = blk; cur_seed = seed;
        wr_start_cyc = -1000; rd_start_cyc = -1000; last_beat = 0;
        for (int k = 0; k < blk * WPB; k++) wr_q.push_back(seed + DW'(k));
        step();
        go_i = 1'b1; blk_cnt_i = 16'(blk); seed_i = seed; go_cyc = cyc;
    endtask

    task automatic finish_run();
        int total, ne, nread;
        bit got, exp_to;
        logic [31:0] fe;
        total = cur_blk * WPB;
        got = 0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (done_o) begin got = 1; break; end
        end
        chk("done", 32'(got), 32'd1);
        ne = 0; fe = 32'hFFFF_FFFF;
        nread = (rd_limit < total) ? rd_limit : total;
        for (int k = 0; k < nread; k++)
            if (corrupt(k)) begin
                if (ne == 0) fe = 32'(k);
                ne++;
            end
        exp_to = (rd_limit < total);
        chk("pass",      32'(pass_o),    32'((ne == 0) && !exp_to));
        chk("timeout",   32'(timeout_o), 32'(exp_to));
        chk("err_cnt",   32'(err_cnt_o), 32'(ne));
        chk("first_err", first_err_idx_o, fe);
        chk("busy_done", 32'(busy_o),    32'd0);
        chk("n_writes",  32'(mem.size()), 32'(total));
        chk("wr_q_left", 32'(wr_q.size()), 32'd0);
        chk("n_starts",  32'(start_cnt), (total > 0) ? 32'd2 : 32'd0);
        if (total > 0) chk("gap_sep", 32'((rd_start_cyc - wr_start_cyc) > GAP), 32'd1);
        // Abort edge is TO edges after the last beat edge; first seen at the following falling edge.
        if (exp_to) chk("to_latency", 32'(cyc - last_beat), 32'(TO + 1));
        if (total == 0) chk("zero_latency", 32'((cyc - go_cyc) <= 2), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"},   32'(emmc_start_o),   32'd0);
        chk({tag, "_we"},      32'(emmc_we_o),      32'd0);
        chk({tag, "_blk"},     32'(emmc_blk_cnt_o), 32'd0);
        chk({tag, "_dat"},     32'(emmc_dat_o),     32'd0);
        chk({tag, "_busy"},    32'(busy_o),         32'd0);
        chk({tag, "_done"},    32'(done_o),         32'd0);
        chk({tag, "_pass"},    32'(pass_o),         32'd0);
        chk({tag, "_timeout"}, 32'(timeout_o),      32'd0);
        chk({tag, "_err"},     32'(err_cnt_o),      32'd0);
        chk({tag, "_first"},   first_err_idx_o,     32'hFFFF_FFFF);
    endtask

    initial begin
        rst_i = 1'b1; go_i = 1'b0; blk_cnt_i = '0; seed_i = '0;
        emmc_ready_i = 1'b0; emmc_dvalid_i = 1'b0; emmc_dat_i = '0;
        wr_act = 0; rd_act = 0; cur_blk = 0; cur_seed = '0; start_cnt = 0;
        wr_left = 0; rd_left = 0; rd_idx = 0; rd_limit = 0; go_busy_at = -1; cmode = 0;
        repeat (3) step();
        chk_reset_outputs("por");
        rst_i = 1'b0;
        step();
        chk("start_at_release", 32'(emmc_start_o), 32'd0);

        begin_run(1, 16'h5555, 0, 0, 1 << 30, -1); finish_run();
        begin_run(1, 16'h5555, 0, 1, 1 << 30, -1); finish_run();
        begin_run(2, 16'h1234, 1, 0, 1 << 30, -1); finish_run();
        begin_run(0, 16'h0042, 0, 0, 1 << 30, -1); finish_run();
        begin_run(1, 16'hABCD, 0, 0, 100, -1);     finish_run();

        begin_run(1, 16'h2222, 0, 0, 1 << 30, -1);
        repeat (50) step();
        wr_act = 0;
        rst_i = 1'b1;
        step();
        chk_reset_outputs("midrun");
        rst_i = 1'b0;
        step();
        chk("start_after_rst", 32'(emmc_start_o), 32'd0);

        begin_run(1, 16'h0F0F, 0, 1, 1 << 30, 100); finish_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/emmc_loopback_seq.md
EMMC_LOOPBACK_SEQ -- requirements
Module: emmc_loopback_seq

Interface
REQ-001 Parameter DATA_W, default 16: width of the host data word exchanged with emmc_sm.
REQ-002 Parameter WORDS_PER_BLK, default 256: words per 512-byte block.
REQ-003 Parameter GAP_CYC, default 16: idle cycles between the write phase and the read phase.
REQ-004 Parameter TIMEOUT_CYC, default 1048576: maximum cycles without a data beat before abort.
REQ-005 Port clk_i, in, 1: single clock; all logic on rising edge.
REQ-006 Port rst_i, in, 1: reset, synchronous, active-high.
REQ-007 Port go_i, in, 1: pulse that starts one write-then-read-back run.
REQ-008 Port blk_cnt_i, in, 16: blocks per run.
REQ-009 Port seed_i, in, DATA_W: pattern seed.
REQ-010 Port emmc_start_o, out, 1: one-cycle start pulse to emmc_sm start_i.
REQ-011 Port emmc_we_o, out, 1: direction to emmc_sm we_i (1 = write).
REQ-012 Port emmc_blk_cnt_o, out, 16: block count to emmc_sm blk_cnt_i.
REQ-013 Port emmc_dat_o, out, DATA_W: write word to emmc_sm dat_i.
REQ-014 Port emmc_ready_i, in, 1: emmc_sm consumed emmc_dat_o this cycle.
REQ-015 Port emmc_dat_i, in, DATA_W: read word from emmc_sm dat_o.
REQ-016 Port emmc_dvalid_i, in, 1: emmc_dat_i valid this cycle.
REQ-017 Port busy_o, out, 1: run in progress.
REQ-018 Port done_o, out, 1: run finished; level.
REQ-019 Port pass_o, out, 1: valid with done_o; no mismatch and no timeout.
REQ-020 Port timeout_o, out, 1: valid with done_o; run aborted on timeout.
REQ-021 Port err_cnt_o, out, 16: count of mismatched read words.
REQ-022 Port first_err_idx_o, out, 32: word index of the first mismatch; 0xFFFFFFFF if none.

Function
REQ-023 States: IDLE, WR_START, WR_DATA, GAP, RD_START, RD_DATA, DONE; all outputs registered.
REQ-024 In IDLE or DONE, go_i=1 latches blk_cnt_i and seed_i, sets total = blk_cnt x WORDS_PER_BLK (32-bit), and clears err_cnt, first_err_idx, timeout, the word index and the timer. Next state is WR_START, or DONE with pass_o=1 if blk_cnt_i=0; no start pulse is issued in that case.
REQ-025 go_i is ignored in every other state.
REQ-026 WR_START lasts 1 cycle: emmc_start_o=1 and emmc_we_o=1 in the cycle after go_i is sampled. Next state is WR_DATA.
REQ-027 Pattern word k = (seed + k) mod 2^DATA_W.
REQ-028 emmc_dat_o presents word k from WR_START onward.
REQ-029 Each cycle with emmc_ready_i=1 in WR_DATA increments k; emmc_dat_o shows word k+1 in the next cycle.
REQ-030 When the write count reaches total, next state is GAP.
REQ-031 GAP holds exactly GAP_CYC cycles, then moves to RD_START; the word index resets to 0 there.
REQ-032 RD_START lasts 1 cycle with emmc_start_o=1 and emmc_we_o=0. Next state is RD_DATA.
REQ-033 Each emmc_dvalid_i=1 cycle in RD_DATA compares emmc_dat_i against word k, then increments k.
REQ-034 On mismatch, err_cnt increments and saturates at 0xFFFF. first_err_idx captures k on the first mismatch only.
REQ-035 When the read count reaches total, next state is DONE.
REQ-036 emmc_ready_i outside WR_DATA and emmc_dvalid_i outside RD_DATA are ignored, including extra beats after total.
REQ-037 Timer: cleared on every beat and on every state entry; increments in WR_DATA and RD_DATA. On reaching TIMEOUT_CYC it forces DONE with timeout_o=1 and pass_o=0.
REQ-038 DONE outputs: done_o=1, busy_o=0, pass_o=(err_cnt=0 and no timeout); all held until the next accepted go_i or reset.
REQ-039 busy_o=1 in every state except IDLE and DONE.
REQ-040 emmc_blk_cnt_o is driven from the latched block count and is stable throughout the run.

Reset
REQ-041 rst_i=1 at a clock edge forces IDLE, including mid-run, and sets every output to 0. Exceptions: first_err_idx_o=0xFFFFFFFF; emmc_dat_o=0.
REQ-042 No emmc_start_o pulse is issued during reset or in the cycle reset is released.

Verification
REQ-043 blk_cnt=1, seed=0x5555, emmc_ready_i=1 every cycle, read model echoes writes -> 256 writes 0x5555..0x5654; then 256 dvalid beats; done_o=1, pass_o=1, err_cnt_o=0, first_err_idx_o=0xFFFFFFFF.
REQ-044 Same run, read word 10 corrupted and words 20 and 30 corrupted -> err_cnt_o=3, first_err_idx_o=10, pass_o=0.
REQ-045 blk_cnt=2, emmc_ready_i toggling every other cycle -> exactly 512 writes with no skipped or repeated pattern word; exactly 2 start pulses (we=1, then we=0) separated by at least GAP_CYC cycles.
REQ-046 blk_cnt=0 -> DONE within 2 cycles, pass_o=1, no emmc_start_o pulse.
REQ-047 TIMEOUT_CYC=64, dvalid stops after 100 read words -> DONE 64 cycles after the last beat, timeout_o=1, pass_o=0.
REQ-048 rst_i asserted mid-WR_DATA -> next cycle IDLE, all outputs at reset values; a subsequent go_i runs normally. go_i pulsed while busy -> no effect.
